// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset supervision blocks.
// Holds the tick-meter FSM state encoding and the expected-count helper.
package clk_rst_pkg;

  localparam int DEFAULT_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_TIMEOUT = 2'd3
  } meter_state_t;

  function automatic int unsigned calc_exp_cnt(input int unsigned clk_freq,
                                               input int unsigned tick_freq);
    return clk_freq / tick_freq;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for tick inputs, one-cycle event output.
// Define TICK_SYNC_EN to insert a 2-flop synchronizer for asynchronous sources.
module tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  output logic tick_evt
);

  logic tick_cur;
  logic tick_prev;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], tick_in};
  end

  assign tick_cur = sync_q[1];
`else
  assign tick_cur = tick_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_prev <= 1'b0;
    else        tick_prev <= tick_cur;
  end

  assign tick_evt = tick_cur & ~tick_prev;

endmodule

// File: rtl/tick_period_meter.sv
// Measures tick spacing in clk cycles, flags range/lock, detects missing ticks.
// Optional input synchronizer in tick_edge_detect is enabled by TICK_SYNC_EN.
//
// state      | meaning
// IDLE       | disabled, outputs cleared except period
// ARM        | waiting for first tick, no reference yet
// MEASURE    | counting cycles since last tick
// TIMEOUT    | tick missing, counter frozen until next tick
module tick_period_meter
  import clk_rst_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned EXPECTED_FREQ = 1,
  parameter int unsigned TOL_CYCLES    = 16,
  parameter int unsigned LOCK_COUNT    = 3,
  parameter int          CNT_W         = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned      EXP_CNT_I = calc_exp_cnt(CLK_FREQ, EXPECTED_FREQ);
  localparam logic [CNT_W-1:0] EXP_CNT   = CNT_W'(EXP_CNT_I);
  localparam logic [CNT_W-1:0] TOL       = CNT_W'(TOL_CYCLES);
  localparam logic [CNT_W-1:0] TO_CNT    = EXP_CNT + TOL;
  localparam logic [3:0]       LOCK_LIM  = 4'(LOCK_COUNT);

  meter_state_t     state, state_nxt;
  logic             tick_evt;
  logic [CNT_W-1:0] cnt, cnt_inc, dev;
  logic [3:0]       lock_cnt, lock_inc;
  logic             period_ok;

  tick_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .tick_evt (tick_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable) state_nxt = ST_ARM;
      ST_ARM:     if (tick_evt) state_nxt = ST_MEASURE;
      ST_MEASURE: if (!tick_evt && cnt == TO_CNT) state_nxt = ST_TIMEOUT;
      ST_TIMEOUT: if (tick_evt) state_nxt = ST_MEASURE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  // Unsigned absolute deviation avoids any signed overflow near the width limit.
  always_comb begin
    cnt_inc   = cnt + 1'b1;
    dev       = (cnt_inc >= EXP_CNT) ? (cnt_inc - EXP_CNT) : (EXP_CNT - cnt_inc);
    period_ok = (dev <= TOL);
    lock_inc  = (lock_cnt >= LOCK_LIM) ? LOCK_LIM : lock_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      lock_cnt     <= 4'd0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        cnt      <= '0;
        lock_cnt <= 4'd0;
        in_range <= 1'b0;
        locked   <= 1'b0;
        timeout  <= 1'b0;
      end else begin
        case (state)
          ST_ARM: if (tick_evt) cnt <= '0;
          ST_MEASURE: begin
            if (tick_evt) begin
              period       <= cnt_inc;
              period_valid <= 1'b1;
              in_range     <= period_ok;
              cnt          <= '0;
              if (period_ok) begin
                lock_cnt <= lock_inc;
                locked   <= (lock_inc >= LOCK_LIM);
              end else begin
                lock_cnt <= 4'd0;
                locked   <= 1'b0;
              end
            end else if (cnt == TO_CNT) begin
              timeout  <= 1'b1;
              in_range <= 1'b0;
              locked   <= 1'b0;
              lock_cnt <= 4'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_TIMEOUT: begin
            if (tick_evt) begin
              timeout <= 1'b0;
              cnt     <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter with EXP_CNT=10, TOL=1, LOCK_COUNT=3.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tick_in = 1'b0;
  logic [31:0] period;
  logic        period_valid, in_range, locked, timeout;

  int total = 0;
  int bad   = 0;

  int          pv_cnt = 0;
  logic [31:0] last_period = '0;
  logic        last_in_range = 1'b0;
  logic        last_locked = 1'b0;
  int          pv_base;

  tick_period_meter #(
    .CLK_FREQ      (100),
    .EXPECTED_FREQ (10),
    .TOL_CYCLES    (1),
    .LOCK_COUNT    (3),
    .CNT_W         (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .tick_in      (tick_in),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (period_valid) begin
      pv_cnt        = pv_cnt + 1;
      last_period   = period;
      last_in_range = in_range;
      last_locked   = locked;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Rising edge now; next rise follows `spacing` cycles later.
  task automatic send_tick(input int spacing, input int hi);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (spacing - hi) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_period", period, 0);
    check("rst_pv", {31'd0, period_valid}, 0);
    check("rst_flags", {28'd0, in_range, locked, timeout, 1'b0}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);

    pv_base = pv_cnt;
    send_tick(10, 1);
    check("arm_no_pv", pv_cnt - pv_base, 0);
    send_tick(10, 1);
    check("p1_period", last_period, 10);
    check("p1_range", {31'd0, last_in_range}, 1);
    check("p1_unlocked", {31'd0, last_locked}, 0);
    send_tick(10, 1);
    send_tick(12, 1);
    check("lock_pv_cnt", pv_cnt - pv_base, 3);
    check("lock_on_3rd", {31'd0, last_locked}, 1);

    send_tick(10, 1);
    check("thr_period", last_period, 12);
    check("thr_range", {31'd0, last_in_range}, 0);
    check("thr_unlock", {31'd0, last_locked}, 0);
    check("thr_no_to", {31'd0, timeout}, 0);
    send_tick(10, 1);
    send_tick(10, 1);
    check("relock_2", {31'd0, last_locked}, 0);
    send_tick(20, 1);
    check("relock_3", {31'd0, last_locked}, 1);
    check("relock_per", last_period, 10);

    pv_base = pv_cnt;
    check("to_flag", {31'd0, timeout}, 1);
    check("to_no_pv", pv_cnt - pv_base, 0);
    check("to_locked", {31'd0, locked}, 0);
    check("to_range", {31'd0, in_range}, 0);
    send_tick(9, 1);
    check("to_clear", {31'd0, timeout}, 0);
    check("to_gap_no_pv", pv_cnt - pv_base, 0);
    send_tick(10, 1);
    check("post_to_per", last_period, 9);
    check("post_to_rng", {31'd0, last_in_range}, 1);

    pv_base = pv_cnt;
    send_tick(10, 5);
    send_tick(10, 5);
    send_tick(4, 5 - 1);
    check("held_pv_cnt", pv_cnt - pv_base, 3);
    check("held_period", last_period, 10);
    check("held_locked", {31'd0, locked}, 1);

    enable = 1'b0;
    @(negedge clk);
    check("dis_locked", {31'd0, locked}, 0);
    check("dis_range", {31'd0, in_range}, 0);
    check("dis_period_hold", period, 10);
    enable = 1'b1;
    @(negedge clk);
    pv_base = pv_cnt;
    send_tick(10, 1);
    check("reen_arm", pv_cnt - pv_base, 0);
    send_tick(4, 1);
    check("reen_pv", pv_cnt - pv_base, 1);
    check("reen_period", last_period, 10);

    rst_n = 1'b0;
    #1;
    check("rst_mid_period", period, 0);
    check("rst_mid_flags", {29'd0, in_range, locked, timeout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pv_base = pv_cnt;
    send_tick(10, 1);
    check("rst_arm", pv_cnt - pv_base, 0);
    send_tick(3, 1);
    check("rst_pv", pv_cnt - pv_base, 1);
    check("rst_period2", last_period, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
